// File: rtl/mem_master_pkg.sv
// mem_master_pkg
// Shared definitions for the mem_master slice.
//   - state_t        : controller state encoding
//   - DEFAULT_DATA_W : default request/response/memory data width
//   - DEFAULT_ADDR_W : default memory address width
//   - DEFAULT_TIMEOUT: default number of WAIT cycles before a read gives up
// Optional statistics are enabled with the macro MEM_MASTER_STATS_EN.
package mem_master_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_ADDR_W  = 4;
  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_master_if.sv
// mem_master_if
// Bundles the request, memory and response channels of mem_master.
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata
//   Memory  : mem_en, mem_address, mem_data_in, mem_data_out, mem_valid_out
//   Response: rsp_valid, rsp_ready, rsp_data, rsp_err
// Modports:
//   master - the mem_master controller itself
//   slave  - the environment (requester, memory and response consumer)
interface mem_master_if
  import mem_master_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_data_out, mem_valid_out,
    input  rsp_ready,
    output req_ready,
    output mem_en, mem_address, mem_data_in,
    output rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_data_out, mem_valid_out,
    output rsp_ready,
    input  req_ready,
    input  mem_en, mem_address, mem_data_in,
    input  rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mem_master_stats.sv
// mem_master_stats
// Saturating 16-bit event counters for mem_master. Only compiled when
// MEM_MASTER_STATS_EN is defined.
//   clk, rst     : clock, synchronous active-high reset
//   i_wr_done    : one-cycle pulse per completed write
//   i_rd_done    : one-cycle pulse per read answered with data
//   i_err_done   : one-cycle pulse per read answered with a timeout error
//   o_wr_count   : completed writes
//   o_rd_count   : completed reads
//   o_err_count  : timeouts
`ifdef MEM_MASTER_STATS_EN
module mem_master_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_done,
  input  logic        i_rd_done,
  input  logic        i_err_done,
  output logic [15:0] o_wr_count,
  output logic [15:0] o_rd_count,
  output logic [15:0] o_err_count
);

  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;
  logic [15:0] r_err_count;

  // Each counter sticks at 0xFFFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (i_wr_done && (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'd1;
      if (i_rd_done && (r_rd_count != 16'hFFFF))
        r_rd_count <= r_rd_count + 16'd1;
      if (i_err_done && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_wr_count  = r_wr_count;
  assign o_rd_count  = r_rd_count;
  assign o_err_count = r_err_count;

endmodule
`endif

// File: rtl/mem_master.sv
// mem_master
// Turns single valid/ready requests into memory write or read cycles and
// returns read data (or a timeout error) on a valid/ready response channel.
//   clk   : clock, all logic on the rising edge
//   rst   : synchronous active-high reset; abandons any operation in flight
//   bus   : mem_master_if.master (request, memory and response channels)
//   wr_count, rd_count, err_count : 16-bit saturating statistics, present
//                                   only when MEM_MASTER_STATS_EN is defined
// Parameters: DATA_W, ADDR_W, TIMEOUT (WAIT cycles before a read errors out).
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  mem_master_if.master bus
`ifdef MEM_MASTER_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] err_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_mem_en;
  logic              w_mem_en;
  logic [ADDR_W-1:0] r_mem_address;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic [DATA_W-1:0] w_mem_data_in;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] w_rsp_data;
  logic              r_rsp_err;
  logic              w_rsp_err;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count;

  // State and all registered outputs. Request fields are copied into the
  // memory-side registers at acceptance, so later req_* changes are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mem_en      <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_mem_en      <= w_mem_en;
      r_mem_address <= w_mem_address;
      r_mem_data_in <= w_mem_data_in;
      r_rsp_data    <= w_rsp_data;
      r_rsp_err     <= w_rsp_err;
      r_count       <= w_count;
    end
  end

  // Next-state and next-output logic. mem_en is a one-cycle pulse, so its
  // default is 0; the other registers hold unless a state updates them.
  always_comb begin
    w_next_state  = r_state;
    w_mem_en      = 1'b0;
    w_mem_address = r_mem_address;
    w_mem_data_in = r_mem_data_in;
    w_rsp_data    = r_rsp_data;
    w_rsp_err     = r_rsp_err;
    w_count       = r_count;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_mem_address = bus.req_addr;
          if (bus.req_write) begin
            w_next_state  = WRITE;
            w_mem_en      = 1'b1;
            w_mem_data_in = bus.req_wdata;
          end else begin
            w_next_state = READ;
          end
        end
      end
      WRITE: begin
        w_next_state = IDLE;
      end
      READ: begin
        w_next_state = WAIT;
        w_count      = '0;
      end
      WAIT: begin
        // Valid data is checked first so it wins over a same-cycle timeout.
        if (bus.mem_valid_out) begin
          w_next_state = RESP;
          w_rsp_data   = bus.mem_data_out;
          w_rsp_err    = 1'b0;
          w_count      = '0;
        end else if (r_count == CNT_W'(TIMEOUT - 1)) begin
          w_next_state = RESP;
          w_rsp_data   = '0;
          w_rsp_err    = 1'b1;
          w_count      = '0;
        end else begin
          w_count = r_count + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.rsp_valid   = (r_state == RESP);
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;

`ifdef MEM_MASTER_STATS_EN
  // Reads are counted when the response is consumed, so an operation
  // abandoned by reset never shows up in the statistics.
  logic w_rsp_fire;
  assign w_rsp_fire = (r_state == RESP) && bus.rsp_ready;

  mem_master_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .i_wr_done   (r_state == WRITE),
    .i_rd_done   (w_rsp_fire && !r_rsp_err),
    .i_err_done  (w_rsp_fire && r_rsp_err),
    .o_wr_count  (wr_count),
    .o_rd_count  (rd_count),
    .o_err_count (err_count)
  );
`endif

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter: DATA_W, default 32, data width of the request, response and memory data buses.
REQ-002 Parameter: ADDR_W, default 4, memory address width.
REQ-003 Parameter: TIMEOUT, default 8, max cycles waiting for mem_valid_out before error response.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  request address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 mem_en  output  1  memory enable; 1 = write cycle, 0 = read/idle.
REQ-012 mem_address  output  ADDR_W  memory address.
REQ-013 mem_data_in  output  DATA_W  memory write data.
REQ-014 mem_data_out  input  DATA_W  memory read data.
REQ-015 mem_valid_out  input  1  memory read data valid; nominally one cycle after read address.
REQ-016 rsp_valid  output  1  read response present.
REQ-017 rsp_ready  input  1  consumer takes response.
REQ-018 rsp_data  output  DATA_W  read data.
REQ-019 rsp_err  output  1  read timed out; rsp_data = 0.

Function
REQ-020 The FSM SHALL have states IDLE, WRITE, READ, WAIT, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-022 On an accepted write, the block SHALL enter WRITE and drive mem_en=1, mem_address=req_addr, mem_data_in=req_wdata for exactly one cycle, then IDLE (req_ready back 2 cycles after acceptance).
REQ-023 On an accepted read, the block SHALL enter READ, driving mem_en=0 and mem_address=req_addr for one cycle, then WAIT.
REQ-024 In WAIT, mem_address SHALL hold; on mem_valid_out=1, mem_data_out SHALL be captured into rsp_data, rsp_err=0, next state RESP.
REQ-025 In WAIT, a counter SHALL count cycles; when it reaches TIMEOUT with no mem_valid_out, next state RESP with rsp_data=0, rsp_err=1.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err stable until rsp_ready=1, then IDLE; rsp_valid=0 in all other states.
REQ-027 mem_valid_out outside WAIT SHALL be ignored.
REQ-028 Request fields SHALL be registered on acceptance; later req_* changes SHALL not affect the operation.
REQ-029 mem_valid_out and timeout in the same cycle: valid data wins, rsp_err=0.
REQ-030 Read nominal latency: accept at N, rsp_valid at N+3.

Reset
REQ-031 On rst=1: state IDLE, mem_en=0, mem_address=0, mem_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout counter 0.
REQ-032 Reset mid-operation SHALL abandon the operation with no response; a late mem_valid_out SHALL be ignored.

Configuration
REQ-033 With MEM_MASTER_STATS_EN defined, outputs wr_count, rd_count, err_count (16 bits each, saturating at 0xFFFF, reset 0) SHALL count completed writes, completed reads and timeouts; without it these ports and their logic SHALL not exist.

Structure
REQ-034 Package mem_master_pkg SHALL hold the state enum type and default DATA_W, ADDR_W, TIMEOUT constants.
REQ-035 Statistics counters SHALL be sub-module mem_master_stats, instantiated only under MEM_MASTER_STATS_EN.

Verification
REQ-036 Write addr 3 data 0xA5A5_0001 -> next cycle mem_en=1, mem_address=3, mem_data_in=0xA5A5_0001, one cycle only.
REQ-037 Write then read addr 3 with a behavioural memory -> rsp_valid 3 cycles after read acceptance, rsp_data=0xA5A5_0001, rsp_err=0.
REQ-038 Read with mem_valid_out held 0 -> after TIMEOUT=8 wait cycles, rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data stable, req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-040 rst asserted during WAIT -> next cycle all outputs at reset values, no response; later mem_valid_out ignored.
REQ-041 With MEM_MASTER_STATS_EN: 2 writes, 1 read, 1 timeout -> wr_count=2, rd_count=1, err_count=1.
